aes_lane_alu_array: RTL and testbench

- Parametrised successor of the 128-bit parallel AES ALU stage. Operates on one AES state plus round key.
- The state is split into 4 columns. Columns go through NUM_LANES identical column lanes, iterated over 4/NUM_LANES cycles.
- Valid/ready handshakes on the input and output sides.
- Sits between the vector register file and writeback in the encryption datapath.

---
 rtl/aes_alu_pkg.sv | 81 ++++++++
 rtl/aes_col_lane.sv | 64 ++++++
 rtl/aes_inv_sbox.sv | 46 ++++
 rtl/aes_sbox.sv | 32 +++
 rtl/aes_lane_alu_array.sv | 138 +++++++++++++
 tb/tb_aes_lane_alu_array.sv | 282 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_alu_pkg.sv
// rtl/aes_alu_pkg.sv - shared types and GF(2^8) helpers for the AES lane ALU
//
// Purpose: op codes, the state width constant, the column type, GF(2^8) constant
//          multipliers and column gather/scatter helpers for the row-major state.
// Ports:   none (package).
// Macro:   AES_INV_EN - when defined, INVSUB and INVMIX are legal op codes.
package aes_alu_pkg;

  localparam int STATE_W = 128;

  typedef logic [31:0] col_t;

  typedef enum logic [2:0] {
    OP_PASS     = 3'b000,
    OP_ADDKEY   = 3'b001,
    OP_SUBBYTES = 3'b010,
    OP_MIXCOL   = 3'b011,
    OP_INVSUB   = 3'b100,
    OP_INVMIX   = 3'b101,
    OP_RSVD6    = 3'b110,
    OP_RSVD7    = 3'b111
  } op_t;

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers used by (Inv)MixColumns: 2, 3, 9, 11, 13, 14; anything else is x1.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'd2:    r = x2;
      4'd3:    r = x2 ^ b;
      4'd9:    r = x8 ^ b;
      4'd11:   r = x8 ^ x2 ^ b;
      4'd13:   r = x8 ^ x4 ^ b;
      4'd14:   r = x8 ^ x4 ^ x2;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic op_illegal(input op_t o);
    logic r;
    case (o)
      OP_PASS, OP_ADDKEY, OP_SUBBYTES, OP_MIXCOL: r = 1'b0;
`ifdef AES_INV_EN
      OP_INVSUB, OP_INVMIX: r = 1'b0;
`endif
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Column c = bytes (0,c),(1,c),(2,c),(3,c), row 0 in the top byte of the column.
  function automatic col_t col_get(input logic [STATE_W-1:0] s, input logic [1:0] c);
    col_t col;
    for (int r = 0; r < 4; r++) begin
      col[31-8*r -: 8] = s[127-32*r-8*int'(c) -: 8];
    end
    return col;
  endfunction

  function automatic logic [STATE_W-1:0] col_put(input logic [STATE_W-1:0] s,
                                                 input logic [1:0] c, input col_t col);
    logic [STATE_W-1:0] o;
    o = s;
    for (int r = 0; r < 4; r++) begin
      o[127-32*r-8*int'(c) -: 8] = col[31-8*r -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_col_lane.sv
// rtl/aes_col_lane.sv - one AES column lane: applies the selected op to one column
//
// Purpose: combinational PASS / ADDKEY / SUBBYTES / MIXCOL (and INVSUB / INVMIX when
//          AES_INV_EN is defined) on a single 32-bit column. Unsupported ops pass
//          the column through unchanged.
// Ports:   op      - operation code
//          col_in  - state column, row 0 in bits [31:24]
//          key_col - matching round key column
//          col_out - processed column
// Macro:   AES_INV_EN - adds inverse S-boxes and the InvMixColumns path.
module aes_col_lane
  import aes_alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] col_in,
  input  logic [31:0] key_col,
  output logic [31:0] col_out
);

  logic [7:0] a   [4];
  logic [7:0] sub [4];
`ifdef AES_INV_EN
  logic [7:0] isub [4];
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_in[31-8*r -: 8];
    aes_sbox u_sbox (
      .in_byte  (a[r]),
      .out_byte (sub[r])
    );
`ifdef AES_INV_EN
    aes_inv_sbox u_inv_sbox (
      .in_byte  (a[r]),
      .out_byte (isub[r])
    );
`endif
  end

  always_comb begin
    col_out = col_in;
    case (op_t'(op))
      OP_ADDKEY:   col_out = col_in ^ key_col;
      OP_SUBBYTES: col_out = {sub[0], sub[1], sub[2], sub[3]};
      OP_MIXCOL: begin
        col_out = {gf_mul(a[0], 4'd2) ^ gf_mul(a[1], 4'd3) ^ a[2] ^ a[3],
                   a[0] ^ gf_mul(a[1], 4'd2) ^ gf_mul(a[2], 4'd3) ^ a[3],
                   a[0] ^ a[1] ^ gf_mul(a[2], 4'd2) ^ gf_mul(a[3], 4'd3),
                   gf_mul(a[0], 4'd3) ^ a[1] ^ a[2] ^ gf_mul(a[3], 4'd2)};
      end
`ifdef AES_INV_EN
      OP_INVSUB:   col_out = {isub[0], isub[1], isub[2], isub[3]};
      OP_INVMIX: begin
        col_out = {gf_mul(a[0], 4'd14) ^ gf_mul(a[1], 4'd11) ^ gf_mul(a[2], 4'd13) ^ gf_mul(a[3], 4'd9),
                   gf_mul(a[0], 4'd9) ^ gf_mul(a[1], 4'd14) ^ gf_mul(a[2], 4'd11) ^ gf_mul(a[3], 4'd13),
                   gf_mul(a[0], 4'd13) ^ gf_mul(a[1], 4'd9) ^ gf_mul(a[2], 4'd14) ^ gf_mul(a[3], 4'd11),
                   gf_mul(a[0], 4'd11) ^ gf_mul(a[1], 4'd13) ^ gf_mul(a[2], 4'd9) ^ gf_mul(a[3], 4'd14)};
      end
`endif
      default:     col_out = col_in;
    endcase
  end

endmodule

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - inverse AES S-box, only present when AES_INV_EN is defined
//
// Purpose: InvSubBytes for one byte: inverse affine transform, then GF(2^8) inverse.
// Ports:   in_byte  - input byte
//          out_byte - inverse-substituted byte
// Macro:   AES_INV_EN - the module exists only in builds with the inverse ops.
`ifdef AES_INV_EN
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul_full(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aes_alu_pkg::xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0): product of x^2 .. x^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] acc;
    p   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul_full(p, p);
      acc = gf_mul_full(acc, p);
    end
    return acc;
  endfunction

  logic [7:0] pre_inv;

  // Inverse of the forward affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign pre_inv  = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                  ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
  assign out_byte = gf_inv(pre_inv);

endmodule
`endif

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box lookup
//
// Purpose: combinational FIPS-197 SubBytes table for one byte.
// Ports:   in_byte  - input byte
//          out_byte - substituted byte
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_lane_alu_array.sv
// rtl/aes_lane_alu_array.sv - AES state ALU iterating 4 columns over NUM_LANES lanes
//
// Purpose: accepts one state + round key, runs the op over the 4 columns using
//          NUM_LANES column lanes (4/NUM_LANES busy cycles), then holds the result
//          until the consumer takes it. No overlap between operations.
// Ports:   clk, rst              - clock, synchronous active-high reset
//          in_valid / in_ready   - operand handshake (ready only in IDLE)
//          op, state_in, key_in  - operation code, row-major state and round key
//          out_valid / out_ready - result handshake (valid only in DONE)
//          state_out             - row-major result
//          err                   - illegal op flag, meaningful while out_valid
// Macro:   AES_INV_EN - enables INVSUB (100) and INVMIX (101); otherwise they are illegal.
module aes_lane_alu_array #(
  parameter int NUM_LANES = 4,
  parameter int STATE_W   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               err
);

  import aes_alu_pkg::*;

  if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
    $error("aes_lane_alu_array: NUM_LANES must be 1, 2 or 4");
  end
  if (STATE_W != aes_alu_pkg::STATE_W) begin : g_bad_width
    $error("aes_lane_alu_array: STATE_W must be 128");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } fsm_t;

  // With 4 lanes the step truncates to 0, which is fine: one BUSY cycle covers everything.
  localparam logic [1:0] LANE_STEP = 2'(NUM_LANES);

  fsm_t               state_q, state_d;
  op_t                op_q, op_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [STATE_W-1:0] key_q, key_d;
  logic               err_q, err_d;
  logic [1:0]         col_idx_q, col_idx_d;

  col_t lane_in  [NUM_LANES];
  col_t lane_key [NUM_LANES];
  col_t lane_out [NUM_LANES];

  // Columns are independent, so results are written back in place over data_q.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_in[l]  = col_get(data_q, col_idx_q + 2'(l));
      lane_key[l] = col_get(key_q, col_idx_q + 2'(l));
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_col_lane u_lane (
      .op      (op_q),
      .col_in  (lane_in[l]),
      .key_col (lane_key[l]),
      .col_out (lane_out[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    key_d     = key_q;
    err_d     = err_q;
    col_idx_d = col_idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d      = op_t'(op);
          data_d    = state_in;
          key_d     = key_in;
          err_d     = op_illegal(op_t'(op));
          col_idx_d = 2'd0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          data_d = col_put(data_d, col_idx_q + 2'(l), lane_out[l]);
        end
        col_idx_d = col_idx_q + LANE_STEP;
        if (int'(col_idx_q) + NUM_LANES >= 4) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d   = ST_IDLE;
          col_idx_d = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_PASS;
      data_q    <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
      col_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      key_q     <= key_d;
      err_q     <= err_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign state_out = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_lane_alu_array.sv
// tb/tb_aes_lane_alu_array.sv - self-checking bench for aes_lane_alu_array
module tb_aes_lane_alu_array;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [2:0]   op        [ND];
  logic [127:0] state_in  [ND];
  logic [127:0] key_in    [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [127:0] state_out [ND];
  logic         err       [ND];

  aes_lane_alu_array #(.NUM_LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op[0]),
    .state_in(state_in[0]), .key_in(key_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .state_out(state_out[0]), .err(err[0]));

  aes_lane_alu_array #(.NUM_LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op[1]),
    .state_in(state_in[1]), .key_in(key_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .state_out(state_out[1]), .err(err[1]));

  aes_lane_alu_array #(.NUM_LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op[2]),
    .state_in(state_in[2]), .key_in(key_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .state_out(state_out[2]), .err(err[2]));

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-boxes from first principles: brute-force inverse, then the affine map.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv;
      logic [7:0] b;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      end
      b = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      sbox_m[x] = b;
      inv_m[b]  = 8'(x);
    end
  endtask

  // Returns {err, result}.
  function automatic logic [128:0] ref_op(input logic [2:0] o, input logic [127:0] s,
                                          input logic [127:0] k);
    logic [7:0] m  [4][4];
    logic [7:0] kb [4][4];
    logic [7:0] r  [4][4];
    logic [7:0] fc [4];
    logic [7:0] ic [4];
    logic [7:0] acc;
    logic [127:0] res;
    logic bad;
    fc[0] = 8'h02; fc[1] = 8'h03; fc[2] = 8'h01; fc[3] = 8'h01;
    ic[0] = 8'h0e; ic[1] = 8'h0b; ic[2] = 8'h0d; ic[3] = 8'h09;
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        m[i][j]  = s[127-32*i-8*j -: 8];
        kb[i][j] = k[127-32*i-8*j -: 8];
        r[i][j]  = m[i][j];
      end
    case (o)
      3'd0: ;
      3'd1: for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = m[i][j] ^ kb[i][j];
      3'd2: for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = sbox_m[m[i][j]];
      3'd3:
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(fc[(j - i + 4) % 4], m[j][c]);
            r[i][c] = acc;
          end
`ifdef AES_INV_EN
      3'd4: for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = inv_m[m[i][j]];
      3'd5:
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(ic[(j - i + 4) % 4], m[j][c]);
            r[i][c] = acc;
          end
`endif
      default: bad = 1'b1;
    endcase
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) res[127-32*i-8*j -: 8] = r[i][j];
    return {bad, res};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Checks acceptance, latency, result, hold stability, release.
  task automatic run_op(input int d, input logic [2:0] o, input logic [127:0] s,
                        input logic [127:0] k, input int hold,
                        input logic [127:0] exp_res, input logic exp_err);
    int   lat;
    logic ok;
    op[d] = o; state_in[d] = s; key_in[d] = k; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready[d]) ok = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("accept d%0d", d), ok, 1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      chk($sformatf("busy_in_ready d%0d", d), in_ready[d], 0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency d%0d op%0d", d, o), lat, 4 / lanes_of(d) + 1);
    chk($sformatf("result d%0d op%0d", d, o), state_out[d], exp_res);
    chk($sformatf("err d%0d op%0d", d, o), err[d], exp_err);
    chk($sformatf("done_in_ready d%0d", d), in_ready[d], 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("hold_data d%0d", d), state_out[d], exp_res);
      chk($sformatf("hold_flags d%0d", d), {out_valid[d], err[d], in_ready[d]}, {1'b1, exp_err, 1'b0});
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk($sformatf("release d%0d", d), {out_valid[d], in_ready[d]}, 2'b01);
  endtask

  logic [2:0]   bo [3];
  logic [127:0] bs [3];
  logic [127:0] bk [3];
  logic [128:0] exq [$];
  logic [128:0] e;
  int           n, got;
  logic         acc_pend;
  logic [2:0]   ro;
  logic [127:0] rs, rk;

  initial begin
    build_tables();
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; op[d] = 3'd0; state_in[d] = '0; key_in[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset d%0d", d), {in_ready[d], out_valid[d], err[d], state_out[d]}, {3'b100, 128'h0});
    end
    rst = 1'b0;

    // Known-answer vectors.
    run_op(2, 3'b001, 128'h328831e0435a3137f6309807a88da234, 128'h2b28ab097eaef7cf15d2154f16a6883c,
           0, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0);
    run_op(0, 3'b010, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 128'h0,
           0, 128'hd4e0b81e27bfb44111985d52aef1e530, 1'b0);
    run_op(1, 3'b011, 128'hd4e0b81ebfb441275d52119830aef1e5, 128'h0,
           3, 128'h04e0482866cbf8068119d326e59a7a4c, 1'b0);
    run_op(2, 3'b111, 128'h00112233445566778899aabbccddeeff, 128'h0123,
           1, 128'h00112233445566778899aabbccddeeff, 1'b1);
`ifdef AES_INV_EN
    run_op(2, 3'b101, 128'h04e0482866cbf8068119d326e59a7a4c, 128'h0,
           0, 128'hd4e0b81ebfb441275d52119830aef1e5, 1'b0);
    run_op(0, 3'b100, 128'hd4e0b81e27bfb44111985d52aef1e530, 128'h0,
           0, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0);
`else
    run_op(2, 3'b100, 128'h00112233445566778899aabbccddeeff, 128'h0,
           0, 128'h00112233445566778899aabbccddeeff, 1'b1);
    run_op(1, 3'b101, 128'hd4e0b81ebfb441275d52119830aef1e5, 128'h0,
           0, 128'hd4e0b81ebfb441275d52119830aef1e5, 1'b1);
`endif

    // Reset during BUSY on the single-lane instance; the in-flight op is illegal so err would be set.
    op[0] = 3'b111; state_in[0] = 128'hdeadbeef; key_in[0] = '0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {in_ready[0], out_valid[0], err[0], state_out[0]}, {3'b100, 128'h0});
    @(negedge clk);
    chk("rst_mid_busy_stays_idle", {in_ready[0], out_valid[0]}, 2'b10);
    run_op(0, 3'b001, 128'h328831e0435a3137f6309807a88da234, 128'h2b28ab097eaef7cf15d2154f16a6883c,
           0, 128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0);

    // Back-to-back with in_valid held high on the two-lane instance.
    bo[0] = 3'b001; bo[1] = 3'b011; bo[2] = 3'b110;
    for (int i = 0; i < 3; i++) begin
      bs[i] = {$urandom, $urandom, $urandom, $urandom};
      bk[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    n = 0; got = 0; acc_pend = 1'b0;
    op[1] = bo[0]; state_in[1] = bs[0]; key_in[1] = bk[0]; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      if (out_valid[1]) begin
        chk("b2b_pending", exq.size() > 0, 1);
        chk("b2b_no_overlap", in_ready[1], 0);
        if (exq.size() > 0) begin
          e = exq.pop_front();
          chk($sformatf("b2b_result%0d", got), {err[1], state_out[1]}, e);
        end
        got++;
      end
      if (acc_pend) begin
        acc_pend = 1'b0;
        n++;
        if (n < 3) begin
          op[1] = bo[n]; state_in[1] = bs[n]; key_in[1] = bk[n];
        end else begin
          in_valid[1] = 1'b0;
        end
      end
      if (in_valid[1] && in_ready[1]) begin
        exq.push_back(ref_op(bo[n], bs[n], bk[n]));
        acc_pend = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b_count", got, 3);
    chk("b2b_accepted", n, 3);
    repeat (3) begin
      chk("b2b_quiet", out_valid[1], 0);
      @(negedge clk);
    end
    out_ready[1] = 1'b0;

    // Randomised ops on every lane configuration against the reference model.
    for (int d = 0; d < ND; d++) begin
      for (int it = 0; it < 12; it++) begin
        ro = 3'($urandom_range(0, 7));
        rs = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        e  = ref_op(ro, rs, rk);
        run_op(d, ro, rs, rk, int'($urandom_range(0, 2)), e[127:0], e[128]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
